// File: rtl/param_lut_table.sv
// param_lut_table: registered, writable lookup table of DEPTH entries x DATA_W bits.
// After reset an INIT sequence copies the built-in default image into the table, one
// entry per cycle. The table then serves one synchronous read per cycle and accepts
// runtime overwrites. Reads sample the old entry when a write hits the same index.
// Optional feature macro: LUT_PARITY_EN adds an even-parity bit per entry, the rd_perr
// output and the inj_perr parity-corruption hook.
module param_lut_table #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 14
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_miss,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack
`ifdef LUT_PARITY_EN
    ,
    output logic              rd_perr,
    input  logic              inj_perr
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DEPTH - 1);
`ifdef LUT_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Default image; indices past the listed values power up as zero.
    function automatic logic [DATA_W-1:0] default_entry(input logic [IDX_W-1:0] idx);
        logic [31:0] val_s;
        case (32'(idx))
            32'd0:   val_s = 32'd3;
            32'd1:   val_s = 32'd71;
            32'd2:   val_s = 32'd18;
            32'd3:   val_s = 32'd115;
            32'd4:   val_s = 32'd35;
            32'd5:   val_s = 32'd31;
            32'd6:   val_s = 32'd89;
            32'd7:   val_s = 32'd31;
            32'd8:   val_s = 32'd17;
            32'd9:   val_s = 32'd5;
            32'd10:  val_s = 32'd8;
            32'd11:  val_s = 32'd14;
            32'd12:  val_s = 32'd2;
            32'd13:  val_s = 32'd5;
            default: val_s = 32'd0;
        endcase
        return DATA_W'(val_s);
    endfunction

`ifdef LUT_PARITY_EN
    // Even parity: the stored bit makes the XOR of data plus parity equal to zero.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction
`endif

    state_t             state_r;
    state_t             next_state_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [ENTRY_W-1:0] mem_r [0:DEPTH-1];

    logic               busy_r;
    logic               rd_valid_r;
    logic [DATA_W-1:0]  rd_data_r;
    logic               rd_miss_r;
    logic               wr_ack_r;

    logic               rd_in_range_s;
    logic               wr_in_range_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               rd_fire_s;
    logic               wr_fire_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]  mem_wdata_raw_s;
    logic [ENTRY_W-1:0] mem_wdata_s;
    logic [ENTRY_W-1:0] rd_entry_s;

`ifdef LUT_PARITY_EN
    logic               rd_perr_r;
    logic               par_flip_s;
`endif

    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_idx_s      = rd_addr[IDX_W-1:0];
    assign wr_idx_s      = wr_addr[IDX_W-1:0];
    assign rd_entry_s    = mem_r[rd_idx_s];

    // Next-state logic: INIT walks every entry once, then READY until the next reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (ptr_r == LAST_IDX_C) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_READY: next_state_s = ST_READY;
            default:  next_state_s = ST_INIT;
        endcase
    end

    // Accepted requests and table write port: INIT fill has priority, user writes only in READY.
    always_comb begin
        rd_fire_s       = (state_r == ST_READY) && rd_req;
        wr_fire_s       = (state_r == ST_READY) && wr_en && wr_in_range_s;
        mem_we_s        = 1'b0;
        mem_waddr_s     = ptr_r;
        mem_wdata_raw_s = default_entry(ptr_r);
`ifdef LUT_PARITY_EN
        par_flip_s      = 1'b0;
`endif
        if (state_r == ST_INIT) begin
            mem_we_s        = ~reset;
            mem_waddr_s     = ptr_r;
            mem_wdata_raw_s = default_entry(ptr_r);
        end else if (wr_fire_s) begin
            mem_we_s        = 1'b1;
            mem_waddr_s     = wr_idx_s;
            mem_wdata_raw_s = wr_data;
`ifdef LUT_PARITY_EN
            par_flip_s      = inj_perr;
`endif
        end else begin
            mem_we_s        = 1'b0;
        end
`ifdef LUT_PARITY_EN
        mem_wdata_s = {even_parity(mem_wdata_raw_s) ^ par_flip_s, mem_wdata_raw_s};
`else
        mem_wdata_s = mem_wdata_raw_s;
`endif
    end

    // State register, fill pointer and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
            ptr_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_INIT);
            if (state_r == ST_INIT) begin
                ptr_r <= ptr_r + IDX_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Table storage; contents need no reset because INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Read port: one registered result per accepted request, held while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_W{1'b0}};
            rd_miss_r  <= 1'b0;
`ifdef LUT_PARITY_EN
            rd_perr_r  <= 1'b0;
`endif
        end else if (rd_fire_s) begin
            rd_valid_r <= 1'b1;
            if (rd_in_range_s) begin
                rd_data_r <= rd_entry_s[DATA_W-1:0];
                rd_miss_r <= 1'b0;
`ifdef LUT_PARITY_EN
                rd_perr_r <= ^rd_entry_s;
`endif
            end else begin
                rd_data_r <= {DATA_W{1'b0}};
                rd_miss_r <= 1'b1;
`ifdef LUT_PARITY_EN
                rd_perr_r <= 1'b0;
`endif
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Write acknowledge: one-cycle pulse after a committed in-range write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ack_r <= 1'b0;
        end else begin
            wr_ack_r <= wr_fire_s;
        end
    end

    assign busy     = busy_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_miss  = rd_miss_r;
    assign wr_ack   = wr_ack_r;
`ifdef LUT_PARITY_EN
    assign rd_perr  = rd_perr_r;
`endif

endmodule

// File: tb/tb_param_lut_table.sv
// Scoreboard bench for param_lut_table: every driven cycle pushes the expected
// outputs, a negedge monitor pops and compares them. Honours LUT_PARITY_EN.
module tb_param_lut_table;

    localparam int DEPTH = 14;

    logic       clk;
    logic       reset;
    logic       busy;
    logic       rd_req;
    logic [5:0] rd_addr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_miss;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
`ifdef LUT_PARITY_EN
    logic       rd_perr;
    logic       inj_perr;
`endif

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       miss;
        logic       perr;
        logic       ack;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       last_e;
    exp_t       mon_e;
    logic [7:0] model_mem [64];
    logic       model_bad [64];
    int         dflt [DEPTH] = '{3, 71, 18, 115, 35, 31, 89, 31, 17, 5, 8, 14, 2, 5};
    int         n_chk  = 0;
    int         n_fail = 0;

    param_lut_table #(.ADDR_W(6), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_miss  (rd_miss),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack)
`ifdef LUT_PARITY_EN
        ,
        .rd_perr  (rd_perr),
        .inj_perr (inj_perr)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic r, input logic [5:0] ra, input logic w,
                              input logic [5:0] wa, input logic [7:0] wd, input logic inj);
        rd_req  = r;
        rd_addr = ra;
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
`ifdef LUT_PARITY_EN
        inj_perr = inj;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = (i < DEPTH) ? 8'(dflt[i]) : 8'd0;
            model_bad[i] = 1'b0;
        end
        last_e = '0;
    endtask

    // One READY cycle: drive inputs, predict outputs, push after the sampling edge.
    task automatic step(input logic r, input logic [5:0] ra, input logic w,
                        input logic [5:0] wa, input logic [7:0] wd, input logic inj);
        exp_t e;
        set_inputs(r, ra, w, wa, wd, inj);
        e = last_e;
        e.valid = r;
        e.ack   = w && (wa < 6'd14);
        if (r) begin
            if (ra < 6'd14) begin
                e.data = model_mem[ra];
                e.miss = 1'b0;
                e.perr = model_bad[ra];
            end else begin
                e.data = 8'd0;
                e.miss = 1'b1;
                e.perr = 1'b0;
            end
            last_e = e;
        end
        if (e.ack) begin
            model_mem[wa] = wd;
            model_bad[wa] = inj;
        end
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_inputs(1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b0);
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        drain();
        reset = 1'b1;
        set_inputs(1'b1, 6'd1, 1'b1, 6'd1, 8'hEE, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_eq("rst_busy",     32'(busy),     32'd1);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data",  32'(rd_data),  32'd0);
        check_eq("rst_rd_miss",  32'(rd_miss),  32'd0);
        check_eq("rst_wr_ack",   32'(wr_ack),   32'd0);
`ifdef LUT_PARITY_EN
        check_eq("rst_rd_perr",  32'(rd_perr),  32'd0);
`endif
    endtask

    // Hammer the ports during INIT, which must ignore them, and measure busy length.
    task automatic wait_init(input int exp_len);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            set_inputs(1'b1, 6'(cnt % 14), 1'b1, 6'(cnt % 14), 8'hFF, 1'b0);
            @(posedge clk);
            #1;
            cnt++;
            check_eq("init_rd_valid", 32'(rd_valid), 32'd0);
            check_eq("init_wr_ack",   32'(wr_ack),   32'd0);
        end
        set_inputs(1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b0);
        check_eq("init_len", 32'(cnt), 32'(exp_len));
    endtask

    // Scoreboard monitor: compare DUT outputs with the oldest prediction.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_eq("rd_valid", 32'(rd_valid), 32'(mon_e.valid));
            check_eq("rd_data",  32'(rd_data),  32'(mon_e.data));
            check_eq("rd_miss",  32'(rd_miss),  32'(mon_e.miss));
            check_eq("wr_ack",   32'(wr_ack),   32'(mon_e.ack));
`ifdef LUT_PARITY_EN
            check_eq("rd_perr",  32'(rd_perr),  32'(mon_e.perr));
`endif
        end
    end

    initial begin
        logic       r;
        logic       w;
        logic [5:0] ra;
        logic [5:0] wa;
        logic [7:0] wd;
        reset = 1'b1;
        set_inputs(1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b0);
        model_reset();

        do_reset();
        wait_init(14);

        // Back-to-back reads; idx 0 also proves INIT ignored the 0xFF writes.
        step(1'b1, 6'd0,  1'b0, 6'd0, 8'd0, 1'b0);
        step(1'b1, 6'd3,  1'b0, 6'd0, 8'd0, 1'b0);
        step(1'b1, 6'd6,  1'b0, 6'd0, 8'd0, 1'b0);
        step(1'b1, 6'd13, 1'b0, 6'd0, 8'd0, 1'b0);
        step(1'b0, 6'd0,  1'b0, 6'd0, 8'd0, 1'b0);

        // Out-of-range reads and a dropped out-of-range write.
        step(1'b1, 6'd14, 1'b0, 6'd0,  8'd0,  1'b0);
        step(1'b1, 6'd63, 1'b0, 6'd0,  8'd0,  1'b0);
        step(1'b0, 6'd0,  1'b1, 6'd20, 8'h77, 1'b0);
        step(1'b1, 6'd13, 1'b0, 6'd0,  8'd0,  1'b0);

        // Same-cycle read/write to idx 4: read-first.
        step(1'b1, 6'd4, 1'b1, 6'd4, 8'hAA, 1'b0);
        step(1'b1, 6'd4, 1'b0, 6'd0, 8'd0,  1'b0);
        step(1'b0, 6'd0, 1'b0, 6'd0, 8'd0,  1'b0);

        // Mixed random traffic around the DEPTH boundary.
        for (int i = 0; i < 30; i++) begin
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ra = 6'($urandom_range(10, 17));
            wa = 6'($urandom_range(10, 17));
            wd = 8'($urandom);
            step(r, ra, w, wa, wd, 1'b0);
        end

`ifdef LUT_PARITY_EN
        // Corrupted parity write is detected, clean rewrite clears it.
        step(1'b0, 6'd0, 1'b1, 6'd2, 8'h12, 1'b1);
        step(1'b1, 6'd2, 1'b0, 6'd0, 8'd0,  1'b0);
        step(1'b0, 6'd0, 1'b1, 6'd2, 8'h34, 1'b0);
        step(1'b1, 6'd2, 1'b0, 6'd0, 8'd0,  1'b0);
        step(1'b1, 6'd63, 1'b0, 6'd0, 8'd0, 1'b0);
`endif

        // Runtime write lost across a reset that also interrupts the next INIT.
        step(1'b0, 6'd0, 1'b1, 6'd1, 8'd200, 1'b0);
        step(1'b1, 6'd1, 1'b0, 6'd0, 8'd0,   1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'b1, 6'd1, 1'b1, 6'd1, 8'h55, 1'b0);
            @(posedge clk);
            #1;
            check_eq("midinit_busy", 32'(busy), 32'd1);
        end
        do_reset();
        wait_init(14);
        step(1'b1, 6'd1, 1'b0, 6'd0, 8'd0, 1'b0);
        step(1'b1, 6'd4, 1'b0, 6'd0, 8'd0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
